// File: rtl/fetch_unit.sv
// fetch_unit: fetch stage and PC owner for the 5-stage WISC pipeline.
//
// Issues one instruction-memory read per cycle, where data returns one cycle after
// the request. Responses are buffered in a small FIFO so that decode stalls never
// drop instructions. Decode can redirect fetch (taken branch/jump) or halt it.
// HALTED is left only by reset.
//
// Optional build macro: FETCH_BYPASS_EN
//   When defined, a response that arrives while the FIFO is empty is presented to
//   decode in the same cycle. When undefined, every response passes through the FIFO.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   imem_req     read request this cycle
//   imem_addr    read address (current PC)
//   imem_rdata   read data, valid the cycle after imem_req
//   id_stall     decode cannot accept this cycle
//   redirect     taken branch/jump from decode
//   redirect_pc  redirect target
//   halt         decode saw HALT
//   instruction  instruction to decode (NOP 16'h0800 when nothing valid)
//   PC_2         address of instruction + 2 (holds last value when nothing valid)
//   if_valid     instruction/PC_2 valid
//   halted       fetch stopped
//   err          sticky misaligned-redirect error
module fetch_unit #(
   parameter int unsigned     PC_W      = 16,
   parameter logic [PC_W-1:0] RESET_PC  = '0,
   parameter int unsigned     BUF_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic [15:0]     imem_rdata,
   input  logic            id_stall,
   input  logic            redirect,
   input  logic [PC_W-1:0] redirect_pc,
   input  logic            halt,
   output logic [15:0]     instruction,
   output logic [PC_W-1:0] PC_2,
   output logic            if_valid,
   output logic            halted,
   output logic            err
);

   localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
   localparam int unsigned OCC_W = CNT_W + 1;
   localparam logic [15:0] NOP   = 16'h0800;

   typedef enum logic {StRun, StHalted} state_e;

   state_e            state_q;
   logic [PC_W-1:0]   pc_q;
   logic [PC_W-1:0]   issued_pc2_q;
   logic              inflight_q;
   logic              squash_q;
   logic              err_q;
   logic [PC_W-1:0]   pc2_last_q;
   logic [PTR_W-1:0]  rd_ptr_q;
   logic [PTR_W-1:0]  wr_ptr_q;
   logic [CNT_W-1:0]  count_q;
   logic [15:0]       instr_mem_q [BUF_DEPTH];
   logic [PC_W-1:0]   pc2_mem_q   [BUF_DEPTH];

   logic              run;
   logic              do_halt;
   logic              do_redirect;
   logic              flush;
   logic              resp_ok;
   logic              fifo_empty;
   logic              bypass;
   logic              pop;
   logic              pop_fifo;
   logic              push_wr;
   logic              issue;
   logic [OCC_W-1:0]  occ;
   logic [OCC_W-1:0]  occ_limit;
   logic [15:0]       instr_out;
   logic [PC_W-1:0]   pc2_out;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_comb begin
      run         = (state_q == StRun);
      do_halt     = run & halt;
      do_redirect = run & ~halt & redirect;
      flush       = do_halt | do_redirect;
      // A flush also kills the response landing this cycle; squash_q covers the next one.
      resp_ok     = inflight_q & ~squash_q & ~flush;
      fifo_empty  = (count_q == '0);
`ifdef FETCH_BYPASS_EN
      bypass      = fifo_empty & resp_ok;
`else
      bypass      = 1'b0;
`endif
      if (!fifo_empty) begin
         instr_out = instr_mem_q[rd_ptr_q];
         pc2_out   = pc2_mem_q[rd_ptr_q];
      end else if (bypass) begin
         instr_out = imem_rdata;
         pc2_out   = issued_pc2_q;
      end else begin
         instr_out = NOP;
         pc2_out   = pc2_last_q;
      end
      if_valid    = ~fifo_empty | bypass;
      pop         = if_valid & ~id_stall & ~flush;
      pop_fifo    = pop & ~fifo_empty;
      // A bypassed response consumed this cycle never needs a FIFO slot.
      push_wr     = resp_ok & ~(bypass & pop);
      // Issue while count + inflight - pop < BUF_DEPTH, written to avoid underflow.
      occ         = OCC_W'(count_q) + OCC_W'(inflight_q);
      occ_limit   = OCC_W'(BUF_DEPTH) + OCC_W'(pop);
      // rst gates the request so nothing is issued while reset is held.
      issue       = rst & run & ~halt & ~redirect & (occ < occ_limit);
   end

   assign imem_req    = issue;
   assign imem_addr   = pc_q;
   assign instruction = instr_out;
   assign PC_2        = pc2_out;
   assign halted      = (state_q == StHalted);
   assign err         = err_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= StRun;
         pc_q         <= RESET_PC;
         issued_pc2_q <= '0;
         inflight_q   <= 1'b0;
         squash_q     <= 1'b0;
         err_q        <= 1'b0;
         pc2_last_q   <= '0;
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         count_q      <= '0;
         for (int i = 0; i < int'(BUF_DEPTH); i++) begin
            instr_mem_q[i] <= NOP;
            pc2_mem_q[i]   <= '0;
         end
      end else begin
         if (do_halt) begin
            state_q <= StHalted;
         end
         if (do_redirect && redirect_pc[0]) begin
            err_q <= 1'b1;
         end
         if (do_redirect) begin
            pc_q <= {redirect_pc[PC_W-1:1], 1'b0};
         end else if (issue) begin
            pc_q <= pc_q + PC_W'(2);
         end
         if (issue) begin
            issued_pc2_q <= pc_q + PC_W'(2);
         end
         inflight_q <= issue;
         squash_q   <= flush;
         pc2_last_q <= pc2_out;
         if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
         end else begin
            if (push_wr) begin
               instr_mem_q[wr_ptr_q] <= imem_rdata;
               pc2_mem_q[wr_ptr_q]   <= issued_pc2_q;
               wr_ptr_q              <= ptr_inc(wr_ptr_q);
            end
            if (pop_fifo) begin
               rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            count_q <= count_q + CNT_W'(push_wr) - CNT_W'(pop_fifo);
         end
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit. Inputs change on the falling edge and outputs are
// sampled 1 time unit later, well away from the rising edge. Memory returns
// 16'hA001 + addr/2 one cycle after a request.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic [15:0] imem_rdata;
   logic        id_stall = 1'b0;
   logic        redirect = 1'b0;
   logic [15:0] redirect_pc = 16'h0000;
   logic        halt = 1'b0;
   logic [15:0] instruction;
   logic [15:0] pc_2;
   logic        if_valid;
   logic        halted;
   logic        err;

   // Second instance for the address-wrap scenario.
   logic        w_req;
   logic [15:0] w_addr;
   logic [15:0] w_rdata;
   logic [15:0] w_instruction;
   logic [15:0] w_pc_2;
   logic        w_if_valid;
   logic        w_halted;
   logic        w_err;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return 16'hA001 + {1'b0, a[15:1]};
   endfunction

   always @(posedge clk) begin
      imem_rdata <= imem_req ? mem_word(imem_addr) : 16'hDEAD;
      w_rdata    <= w_req ? mem_word(w_addr) : 16'hDEAD;
   end

   fetch_unit #(.PC_W(16), .RESET_PC(16'h0000), .BUF_DEPTH(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_rdata (imem_rdata),
      .id_stall   (id_stall),
      .redirect   (redirect),
      .redirect_pc(redirect_pc),
      .halt       (halt),
      .instruction(instruction),
      .PC_2       (pc_2),
      .if_valid   (if_valid),
      .halted     (halted),
      .err        (err)
   );

   fetch_unit #(.PC_W(16), .RESET_PC(16'hFFFC), .BUF_DEPTH(2)) dut_wrap (
      .clk        (clk),
      .rst        (rst),
      .imem_req   (w_req),
      .imem_addr  (w_addr),
      .imem_rdata (w_rdata),
      .id_stall   (1'b0),
      .redirect   (1'b0),
      .redirect_pc(16'h0000),
      .halt       (1'b0),
      .instruction(w_instruction),
      .PC_2       (w_pc_2),
      .if_valid   (w_if_valid),
      .halted     (w_halted),
      .err        (w_err)
   );

   task automatic test_reset();
      @(negedge clk); #1;
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", imem_req); end
      checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", if_valid); end
      checks++; if (instruction !== 16'h0800) begin errors++; $display("FAIL rst_instr got %h want 0800", instruction); end
      checks++; if (pc_2 !== 16'h0000) begin errors++; $display("FAIL rst_pc2 got %h want 0000", pc_2); end
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted got %b want 0", halted); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", err); end
   endtask

   // Cycles C0..C5 after reset release.
   task automatic test_stream();
      logic [15:0] ea;
      logic [15:0] ep;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (k == 0) rst = 1'b1;
         #1;
         ea = 16'(2 * k);
         checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL stream_req k=%0d got %b want 1", k, imem_req); end
         checks++; if (imem_addr !== ea) begin errors++; $display("FAIL stream_addr k=%0d got %h want %h", k, imem_addr, ea); end
         if (k < 2) begin
            checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL stream_valid k=%0d got %b want 0", k, if_valid); end
         end else begin
            ep = 16'(2 * (k - 2) + 2);
            checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL stream_valid k=%0d got %b want 1", k, if_valid); end
            checks++; if (pc_2 !== ep) begin errors++; $display("FAIL stream_pc2 k=%0d got %h want %h", k, pc_2, ep); end
            checks++; if (instruction !== mem_word(ep - 16'd2)) begin errors++; $display("FAIL stream_instr k=%0d got %h want %h", k, instruction, mem_word(ep - 16'd2)); end
         end
      end
   endtask

   // C6..C9 stalled, C10..C13 resume.
   task automatic test_stall();
      logic [15:0] ep;
      logic [15:0] ea;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         id_stall = 1'b1;
         #1;
         checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req k=%0d got %b want 0", k, imem_req); end
         checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL stall_valid k=%0d got %b want 1", k, if_valid); end
         checks++; if (pc_2 !== 16'h000A) begin errors++; $display("FAIL stall_pc2 k=%0d got %h want 000a", k, pc_2); end
         checks++; if (instruction !== 16'hA005) begin errors++; $display("FAIL stall_instr k=%0d got %h want a005", k, instruction); end
      end
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         id_stall = 1'b0;
         #1;
         ep = 16'(16'h000A + 2 * j);
         ea = 16'(16'h000C + 2 * j);
         checks++; if (pc_2 !== ep) begin errors++; $display("FAIL resume_pc2 j=%0d got %h want %h", j, pc_2, ep); end
         checks++; if (instruction !== mem_word(ep - 16'd2)) begin errors++; $display("FAIL resume_instr j=%0d got %h want %h", j, instruction, mem_word(ep - 16'd2)); end
         checks++; if (imem_addr !== ea || imem_req !== 1'b1) begin errors++; $display("FAIL resume_addr j=%0d got %h/%b want %h/1", j, imem_addr, imem_req, ea); end
      end
   endtask

   // C14..C17.
   task automatic test_redirect();
      @(negedge clk);
      redirect = 1'b1; redirect_pc = 16'h0040;
      #1;
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL redir_req got %b want 0", imem_req); end
      @(negedge clk);
      redirect = 1'b0;
      #1;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0040) begin errors++; $display("FAIL redir_addr got %h/%b want 0040/1", imem_addr, imem_req); end
      checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL redir_flush got %b want 0", if_valid); end
      checks++; if (instruction !== 16'h0800) begin errors++; $display("FAIL redir_nop got %h want 0800", instruction); end
      checks++; if (pc_2 !== 16'h0012) begin errors++; $display("FAIL redir_hold got %h want 0012", pc_2); end
      @(negedge clk); #1;
      checks++; if (if_valid !== 1'b0 || imem_addr !== 16'h0042) begin errors++; $display("FAIL redir_c2 got %b/%h want 0/0042", if_valid, imem_addr); end
      @(negedge clk); #1;
      checks++; if (if_valid !== 1'b1 || pc_2 !== 16'h0042) begin errors++; $display("FAIL redir_first got %b/%h want 1/0042", if_valid, pc_2); end
      checks++; if (instruction !== 16'hA021) begin errors++; $display("FAIL redir_instr got %h want a021", instruction); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL redir_err got %b want 0", err); end
   endtask

   // C18..C21.
   task automatic test_misaligned();
      @(negedge clk);
      redirect = 1'b1; redirect_pc = 16'h0041;
      @(negedge clk);
      redirect = 1'b0;
      #1;
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL mis_err got %b want 1", err); end
      checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0040) begin errors++; $display("FAIL mis_addr got %h/%b want 0040/1", imem_addr, imem_req); end
      @(negedge clk);
      @(negedge clk); #1;
      checks++; if (if_valid !== 1'b1 || pc_2 !== 16'h0042) begin errors++; $display("FAIL mis_first got %b/%h want 1/0042", if_valid, pc_2); end
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL mis_sticky got %b want 1", err); end
   endtask

   // C22..C29.
   task automatic test_halt();
      @(negedge clk);
      halt = 1'b1; redirect = 1'b1; redirect_pc = 16'h0080;
      #1;
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL halt_req0 got %b want 0", imem_req); end
      @(negedge clk);
      halt = 1'b0; redirect = 1'b0;
      #1;
      checks++; if (halted !== 1'b1 || imem_req !== 1'b0 || if_valid !== 1'b0) begin errors++; $display("FAIL halt_state got h=%b r=%b v=%b want 1/0/0", halted, imem_req, if_valid); end
      @(negedge clk);
      redirect = 1'b1; redirect_pc = 16'h0100;
      #1;
      checks++; if (halted !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL halt_ignore got h=%b r=%b want 1/0", halted, imem_req); end
      @(negedge clk);
      redirect = 1'b0;
      #1;
      checks++; if (halted !== 1'b1 || imem_req !== 1'b0 || if_valid !== 1'b0) begin errors++; $display("FAIL halt_hold got h=%b r=%b v=%b want 1/0/0", halted, imem_req, if_valid); end
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL halt_err got %b want 1", err); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++; if (halted !== 1'b0 || err !== 1'b0 || if_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL mid_rst got h=%b e=%b v=%b r=%b want 0/0/0/0", halted, err, if_valid, imem_req); end
      checks++; if (instruction !== 16'h0800 || pc_2 !== 16'h0000) begin errors++; $display("FAIL mid_rst_out got %h/%h want 0800/0000", instruction, pc_2); end
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin errors++; $display("FAIL restart_addr got %h/%b want 0000/1", imem_addr, imem_req); end
      @(negedge clk); #1;
      checks++; if (imem_addr !== 16'h0002 || if_valid !== 1'b0) begin errors++; $display("FAIL restart_c1 got %h/%b want 0002/0", imem_addr, if_valid); end
      @(negedge clk); #1;
      checks++; if (if_valid !== 1'b1 || pc_2 !== 16'h0002 || instruction !== 16'hA001) begin errors++; $display("FAIL restart_first got %b/%h/%h want 1/0002/a001", if_valid, pc_2, instruction); end
   endtask

   task automatic test_wrap();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++; if (w_req !== 1'b1 || w_addr !== 16'hFFFC) begin errors++; $display("FAIL wrap_a0 got %h/%b want fffc/1", w_addr, w_req); end
      @(negedge clk); #1;
      checks++; if (w_addr !== 16'hFFFE) begin errors++; $display("FAIL wrap_a1 got %h want fffe", w_addr); end
      @(negedge clk); #1;
      checks++; if (w_addr !== 16'h0000) begin errors++; $display("FAIL wrap_a2 got %h want 0000", w_addr); end
      checks++; if (w_if_valid !== 1'b1 || w_pc_2 !== 16'hFFFE || w_instruction !== 16'h1FFF) begin errors++; $display("FAIL wrap_d0 got %b/%h/%h want 1/fffe/1fff", w_if_valid, w_pc_2, w_instruction); end
      @(negedge clk); #1;
      checks++; if (w_pc_2 !== 16'h0000 || w_instruction !== 16'h2000) begin errors++; $display("FAIL wrap_d1 got %h/%h want 0000/2000", w_pc_2, w_instruction); end
      @(negedge clk); #1;
      checks++; if (w_pc_2 !== 16'h0002 || w_instruction !== 16'hA001) begin errors++; $display("FAIL wrap_d2 got %h/%h want 0002/a001", w_pc_2, w_instruction); end
      checks++; if (w_halted !== 1'b0 || w_err !== 1'b0) begin errors++; $display("FAIL wrap_flags got %b/%b want 0/0", w_halted, w_err); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_redirect();
      test_misaligned();
      test_halt();
      test_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
